// File: rtl/uart_cmd_handler_mc.sv
// Multi-channel UART command handler: decodes a byte protocol into per-channel
// glitch configuration registers, fires trigger strobes and answers with ACK/NAK/data.

module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB) + 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  rx_state_e      state;
  logic [1:0]     sync_q;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= R_IDLE;
      sync_q  <= 2'b11;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      valid  <= 1'b0;
      case (state)
        R_IDLE: if (!sync_q[1]) begin
          cnt   <= '0;
          state <= R_START;
        end
        R_START: if (cnt == CW'(CPB / 2 - 1)) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= sync_q[1] ? R_IDLE : R_DATA;  // reject glitches shorter than half a bit
        end else cnt <= cnt + 1'b1;
        R_DATA: if (cnt == CW'(CPB - 1)) begin
          cnt     <= '0;
          shreg   <= {sync_q[1], shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= R_STOP;
        end else cnt <= cnt + 1'b1;
        R_STOP: if (cnt == CW'(CPB - 1)) begin
          if (sync_q[1]) begin
            data  <= shreg;
            valid <= 1'b1;
          end
          state <= R_IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= R_IDLE;
      endcase
    end
  end
endmodule

module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB) + 1;

  logic [9:0]    sh;
  logic [CW-1:0] cnt;
  logic [3:0]    nbit;

  assign tx = sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '1;
      cnt  <= '0;
      nbit <= '0;
      busy <= 1'b0;
    end else if (!busy) begin
      if (en) begin
        sh   <= {1'b1, data, 1'b0};
        cnt  <= '0;
        nbit <= '0;
        busy <= 1'b1;
      end
    end else if (cnt == CW'(CPB - 1)) begin
      cnt  <= '0;
      sh   <= {1'b1, sh[9:1]};
      nbit <= nbit + 1'b1;
      if (nbit == 4'd9) busy <= 1'b0;
    end else cnt <= cnt + 1'b1;
  end
endmodule

module uart_cmd_handler_mc #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int NUM_CH         = 2,
  parameter int DELAY_W        = 16,
  parameter int WIDTH_W        = 8,
  parameter int PULSES_W       = 8,
  parameter int SPACING_W      = 16,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx_i,
  output logic                          uart_tx_o,
  output logic [NUM_CH*DELAY_W-1:0]     delay_o,
  output logic [NUM_CH*WIDTH_W-1:0]     width_o,
  output logic [NUM_CH*PULSES_W-1:0]    num_pulses_o,
  output logic [NUM_CH*SPACING_W-1:0]   pulse_spacing_o,
  output logic [NUM_CH-1:0]             pulse_en_o,
  output logic                          busy_o
);
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] ACK      = 8'h4B;
  localparam logic [7:0] NAK      = 8'h21;
  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_ARG, S_EXEC, S_SEND} state_e;
  typedef enum logic [2:0] {C_DELAY, C_WIDTH, C_PULSES, C_SPACING, C_TRIG, C_SEL, C_READ} cmd_e;

  function automatic logic [2:0] arg_bytes(input logic [2:0] op);
    case (op)
      3'd0:    return 3'(DELAY_W / 8);
      3'd1:    return 3'(WIDTH_W / 8);
      3'd2:    return 3'(PULSES_W / 8);
      3'd3:    return 3'(SPACING_W / 8);
      default: return 3'd1;
    endcase
  endfunction

  state_e              state;
  cmd_e                cmd;
  logic [2:0]          arg_cnt;
  logic [31:0]         staging;
  logic [TMO_W-1:0]    tmo;
  logic [47:0]         tx_buf;
  logic [2:0]          tx_cnt;
  logic                tx_en;
  logic [7:0]          tx_data;
  logic                tx_busy;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [CH_W-1:0]     sel_ch;
  logic [NUM_CH-1:0]   pulse_en;
  logic [DELAY_W-1:0]   delay_r   [NUM_CH];
  logic [WIDTH_W-1:0]   width_r   [NUM_CH];
  logic [PULSES_W-1:0]  pulses_r  [NUM_CH];
  logic [SPACING_W-1:0] spacing_r [NUM_CH];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(uart_rx_i), .data(rx_data), .valid(rx_valid)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk(clk), .rst_n(rst_n), .en(tx_en), .data(tx_data), .tx(uart_tx_o), .busy(tx_busy)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign delay_o[c*DELAY_W +: DELAY_W]             = delay_r[c];
    assign width_o[c*WIDTH_W +: WIDTH_W]             = width_r[c];
    assign num_pulses_o[c*PULSES_W +: PULSES_W]      = pulses_r[c];
    assign pulse_spacing_o[c*SPACING_W +: SPACING_W] = spacing_r[c];
  end

  assign pulse_en_o = pulse_en;
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cmd      <= C_DELAY;
      arg_cnt  <= '0;
      staging  <= '0;
      tmo      <= '0;
      tx_buf   <= '0;
      tx_cnt   <= '0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      sel_ch   <= '0;
      pulse_en <= '0;
      // NOTE: these arrays are a handful of config registers driving outputs, not RAM, so they take the reset.
      for (int c = 0; c < NUM_CH; c++) begin
        delay_r[c]   <= '0;
        width_r[c]   <= '0;
        pulses_r[c]  <= '0;
        spacing_r[c] <= '0;
      end
    end else begin
      tx_en    <= 1'b0;
      pulse_en <= '0;
      case (state)
        S_IDLE: if (rx_valid) begin
          staging <= '0;
          tmo     <= '0;
          if (rx_data <= 8'h06) begin
            cmd     <= cmd_e'(rx_data[2:0]);
            arg_cnt <= arg_bytes(rx_data[2:0]);
            state   <= S_ARG;
          end else if (rx_data == 8'h68) begin
            tx_buf <= 48'h48_65_6C_6C_6F_0A;
            tx_cnt <= 3'd6;
            state  <= S_SEND;
          end else begin
            tx_buf <= {rx_data, 40'h0};
            tx_cnt <= 3'd1;
            state  <= S_SEND;
          end
        end
        S_ARG: if (rx_valid) begin
          staging <= {staging[23:0], rx_data};
          tmo     <= '0;
          arg_cnt <= arg_cnt - 1'b1;
          if (arg_cnt == 3'd1) state <= S_EXEC;
        end else if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          staging <= '0;
          tx_buf  <= {NAK, 40'h0};
          tx_cnt  <= 3'd1;
          state   <= S_SEND;
        end else tmo <= tmo + 1'b1;
        S_EXEC: begin
          tx_buf <= {ACK, 40'h0};
          tx_cnt <= 3'd1;
          state  <= S_SEND;
          case (cmd)
            C_DELAY:   delay_r[sel_ch]   <= staging[DELAY_W-1:0];
            C_WIDTH:   width_r[sel_ch]   <= staging[WIDTH_W-1:0];
            C_PULSES:  pulses_r[sel_ch]  <= staging[PULSES_W-1:0];
            C_SPACING: spacing_r[sel_ch] <= staging[SPACING_W-1:0];
            C_TRIG:    pulse_en          <= staging[NUM_CH-1:0];
            C_SEL:
              if (staging[7:0] < NUM_CH_B) sel_ch <= staging[CH_W-1:0];
              else tx_buf <= {NAK, 40'h0};
            C_READ:    // read-back replaces the ACK with the value, left-aligned for MSB-first shifting
              case (staging[7:0])
                8'd0: begin tx_buf <= 48'(delay_r[sel_ch])   << (48 - DELAY_W);   tx_cnt <= 3'(DELAY_W / 8);   end
                8'd1: begin tx_buf <= 48'(width_r[sel_ch])   << (48 - WIDTH_W);   tx_cnt <= 3'(WIDTH_W / 8);   end
                8'd2: begin tx_buf <= 48'(pulses_r[sel_ch])  << (48 - PULSES_W);  tx_cnt <= 3'(PULSES_W / 8);  end
                8'd3: begin tx_buf <= 48'(spacing_r[sel_ch]) << (48 - SPACING_W); tx_cnt <= 3'(SPACING_W / 8); end
                default: tx_buf <= {NAK, 40'h0};
              endcase
            default: ;
          endcase
        end
        S_SEND: if (!tx_en && !tx_busy) begin
          tx_en   <= 1'b1;
          tx_data <= tx_buf[47:40];
          tx_buf  <= {tx_buf[39:0], 8'h0};
          tx_cnt  <= tx_cnt - 1'b1;
          if (tx_cnt == 3'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_handler_mc.sv
// Scoreboard bench for uart_cmd_handler_mc: drives serial commands, a monitor
// decodes the serial response and compares against queued expected bytes.

module tb_uart_cmd_handler_mc;
  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int NUM_CH    = 2;
  localparam int TMO       = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        uart_tx_o;
  logic [31:0] delay_o;
  logic [15:0] width_o;
  logic [15:0] num_pulses_o;
  logic [31:0] pulse_spacing_o;
  logic [1:0]  pulse_en_o;
  logic        busy_o;

  uart_cmd_handler_mc #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .NUM_CH(NUM_CH),
    .DELAY_W(16), .WIDTH_W(8), .PULSES_W(8), .SPACING_W(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(rx), .uart_tx_o(uart_tx_o),
    .delay_o(delay_o), .width_o(width_o), .num_pulses_o(num_pulses_o),
    .pulse_spacing_o(pulse_spacing_o), .pulse_en_o(pulse_en_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         strobe_cnt = 0;
  logic [1:0] strobe_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pulse_en_o != 2'b00) begin
      strobe_cnt++;
      strobe_val = pulse_en_o;
    end
  end

  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx_o == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx_o;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", 64'(uart_tx_o), 64'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_unexpected: got %02h, expected no byte", b);
        end else begin
          check("tx_byte", 64'(b), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = frame[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic expect_b(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("resp_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (30) @(negedge clk);
  endtask

  int base;

  initial begin
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("rst_delay",   64'(delay_o), 64'd0);
    check("rst_width",   64'(width_o), 64'd0);
    check("rst_pulses",  64'(num_pulses_o), 64'd0);
    check("rst_spacing", 64'(pulse_spacing_o), 64'd0);
    check("rst_pulse_en", 64'(pulse_en_o), 64'd0);
    check("rst_busy",    64'(busy_o), 64'd0);

    expect_b(8'h4B);
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    wait_resp();
    check("delay_ch0_write", 64'(delay_o), 64'h0000_1234);

    expect_b(8'h4B);
    send_byte(8'h05); send_byte(8'h01);
    wait_resp();
    expect_b(8'h4B);
    send_byte(8'h01); send_byte(8'h7F);
    wait_resp();
    check("width_ch1_write", 64'(width_o), 64'h7F00);

    base = strobe_cnt;
    expect_b(8'h4B);
    send_byte(8'h04); send_byte(8'h03);
    wait_resp();
    check("trig_strobe_cycles", 64'(strobe_cnt - base), 64'd1);
    check("trig_strobe_mask",   64'(strobe_val), 64'h3);

    base = strobe_cnt;
    expect_b(8'h4B);
    send_byte(8'h04); send_byte(8'hFC);
    wait_resp();
    check("trig_high_mask_none", 64'(strobe_cnt - base), 64'd0);

    expect_b(8'h21);
    send_byte(8'h05); send_byte(8'h02);
    wait_resp();
    expect_b(8'h4B);
    send_byte(8'h02); send_byte(8'h05);
    wait_resp();
    check("sel_kept_pulses_ch1", 64'(num_pulses_o), 64'h0500);

    expect_b(8'h21);
    send_byte(8'h06); send_byte(8'h07);
    wait_resp();

    expect_b(8'h4B);
    send_byte(8'h00); send_byte(8'hBE); send_byte(8'hEF);
    wait_resp();
    check("delay_ch1_write", 64'(delay_o), 64'hBEEF_1234);
    expect_b(8'hBE); expect_b(8'hEF);
    send_byte(8'h06); send_byte(8'h00);
    wait_resp();
    expect_b(8'h7F);
    send_byte(8'h06); send_byte(8'h01);
    wait_resp();

    send_byte(8'h03); send_byte(8'hAA);
    repeat (20) @(negedge clk);
    check("busy_in_arg", 64'(busy_o), 64'd1);
    expect_b(8'h21);
    wait_resp();
    check("timeout_spacing", 64'(pulse_spacing_o), 64'd0);
    check("timeout_idle", 64'(busy_o), 64'd0);

    expect_b(8'h48); expect_b(8'h65); expect_b(8'h6C);
    expect_b(8'h6C); expect_b(8'h6F); expect_b(8'h0A);
    send_byte(8'h68);
    wait_resp();
    expect_b(8'h99);
    send_byte(8'h99);
    wait_resp();

    send_byte(8'h00); send_byte(8'hAB);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_arg_rst_delay",   64'(delay_o), 64'd0);
    check("mid_arg_rst_width",   64'(width_o), 64'd0);
    check("mid_arg_rst_pulses",  64'(num_pulses_o), 64'd0);
    check("mid_arg_rst_busy",    64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5 * CPB) @(negedge clk);

    expect_b(8'h4B);
    send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
    wait_resp();
    check("post_rst_delay_ch0", 64'(delay_o), 64'h0000_5566);

    repeat (200) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
